// File: rtl/pq_pkg.sv
// Shared types and helpers for the priority-queue requester.
package pq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_ENQ  = 2'd1,
        CMD_DEQ  = 2'd2,
        CMD_REP  = 2'd3
    } cmd_e;

    // Bits needed to hold settle counts 0..cycles-1 (never narrower than 1).
    function automatic int settle_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pq_settle_timer.sv
// Loadable down-counter; done while the count sits at zero.
module pq_settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/pq_requester.sv
// Client-side initiator for the register-tree max-heap: turns push/pop
// handshakes into single-cycle wrt/read commands followed by settle time.
module pq_requester
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 4095,
    parameter int SETTLE_CYCLES = 12
) (
    input  logic                            i_CLK,
    input  logic                            i_RST,
    input  logic                            i_push_valid,
    output logic                            o_push_ready,
    input  logic [DATA_WIDTH-1:0]           i_push_data,
    input  logic                            i_pop_valid,
    output logic                            o_pop_ready,
    output logic                            o_pop_data_valid,
    input  logic                            i_pop_data_ready,
    output logic [DATA_WIDTH-1:0]           o_pop_data,
    output logic                            o_pq_wrt,
    output logic                            o_pq_read,
    output logic [DATA_WIDTH-1:0]           o_pq_data,
    input  logic                            i_pq_full,
    input  logic                            i_pq_empty,
    input  logic [DATA_WIDTH-1:0]           i_pq_data,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic                            o_busy,
    output logic                            o_drop,
    output logic                            o_mismatch
);

    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int SW = settle_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] QS_C    = CW'(QUEUE_SIZE);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    state_e                state_q, state_d;
    cmd_e                  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  pop_data_valid_q, pop_data_valid_d;
    logic                  drop_q, drop_d;
    logic                  mismatch_q, mismatch_d;

    logic idle;
    logic push_fire;
    logic pop_fire;
    logic push_nz;
    logic timer_load;
    logic timer_done;

    pq_settle_timer #(
        .WIDTH(SW)
    ) u_settle_timer (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_load (timer_load),
        .i_value(SETTLE_LOAD),
        .o_done (timer_done)
    );

    assign idle = (state_q == IDLE);

    // A push into a full queue is only legal when it pairs with a pop (replace).
    assign o_pop_ready  = idle && !i_RST && (count_q != '0) && !pop_data_valid_q;
    assign o_push_ready = idle && !i_RST && ((count_q < QS_C) || (i_pop_valid && o_pop_ready));

    assign push_fire = i_push_valid && o_push_ready;
    assign pop_fire  = i_pop_valid && o_pop_ready;
    assign push_nz   = (i_push_data != '0);

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        key_d            = key_q;
        count_d          = count_q;
        pop_data_d       = pop_data_q;
        pop_data_valid_d = pop_data_valid_q && !i_pop_data_ready;
        drop_d           = 1'b0;
        timer_load       = 1'b0;
        mismatch_d       = mismatch_q;

        if (idle && ((i_pq_empty != (count_q == '0)) || (i_pq_full != (count_q >= QS_C)))) begin
            mismatch_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                drop_d = push_fire && !push_nz;
                if (push_fire && push_nz && pop_fire) begin
                    cmd_d   = CMD_REP;
                    key_d   = i_push_data;
                    state_d = ISSUE;
                end else if (push_fire && push_nz) begin
                    cmd_d   = CMD_ENQ;
                    key_d   = i_push_data;
                    state_d = ISSUE;
                end else if (pop_fire) begin
                    cmd_d   = CMD_DEQ;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_load = 1'b1;
                state_d    = SETTLE;
                unique case (cmd_q)
                    CMD_ENQ: count_d = count_q + 1'b1;
                    CMD_DEQ: begin
                        count_d          = count_q - 1'b1;
                        pop_data_d       = i_pq_data;
                        pop_data_valid_d = 1'b1;
                    end
                    CMD_REP: begin
                        pop_data_d       = i_pq_data;
                        pop_data_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            SETTLE: begin
                if (timer_done) begin
                    state_d = IDLE;
                    cmd_d   = CMD_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q          <= IDLE;
            cmd_q            <= CMD_NONE;
            key_q            <= '0;
            count_q          <= '0;
            pop_data_q       <= '0;
            pop_data_valid_q <= 1'b0;
            drop_q           <= 1'b0;
            mismatch_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            key_q            <= key_d;
            count_q          <= count_d;
            pop_data_q       <= pop_data_d;
            pop_data_valid_q <= pop_data_valid_d;
            drop_q           <= drop_d;
            mismatch_q       <= mismatch_d;
        end
    end

    assign o_pq_wrt  = (state_q == ISSUE) && ((cmd_q == CMD_ENQ) || (cmd_q == CMD_REP));
    assign o_pq_read = (state_q == ISSUE) && ((cmd_q == CMD_DEQ) || (cmd_q == CMD_REP));
    assign o_pq_data = o_pq_wrt ? key_q : '0;

    assign o_pop_data       = pop_data_q;
    assign o_pop_data_valid = pop_data_valid_q;
    assign o_count          = count_q;
    assign o_busy           = !idle;
    assign o_drop           = drop_q;
    assign o_mismatch       = mismatch_q;

endmodule

// File: doc/pq_requester.md
Name: pq_requester

Overview:
- Client-side initiator for the register-tree priority queue (max-heap; value 0 means empty slot).
- Turns independent valid/ready push and pop requests into the queue's single-cycle wrt/read commands. Simultaneous push+pop becomes a replace.
- Inserts idle settle cycles after every command so the tree's compare-and-swap passes restore heap order before the next access.
- Returns popped data on a valid/ready response channel, keeps an occupancy count, and rejects zero-valued pushes.

Parameters:
- DATA_WIDTH, 16, key width; must match the queue.
- QUEUE_SIZE, 4095, queue capacity; must match the queue.
- SETTLE_CYCLES, 12, idle cycles after each issued command; at least 1; nominally $clog2(QUEUE_SIZE).

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset; synchronous, active-high, one clock.
- i_push_valid  in  1  push request.
- o_push_ready  out  1  push accepted when valid&&ready.
- i_push_data  in  DATA_WIDTH  key to insert.
- i_pop_valid  in  1  pop request.
- o_pop_ready  out  1  pop accepted when valid&&ready.
- o_pop_data_valid  out  1  popped key available.
- i_pop_data_ready  in  1  consumer takes the popped key.
- o_pop_data  out  DATA_WIDTH  popped key (the maximum).
- o_pq_wrt  out  1  to queue i_wrt.
- o_pq_read  out  1  to queue i_read.
- o_pq_data  out  DATA_WIDTH  to queue i_data.
- i_pq_full  in  1  from queue o_full.
- i_pq_empty  in  1  from queue o_empty.
- i_pq_data  in  DATA_WIDTH  from queue o_data (root).
- o_count  out  $clog2(QUEUE_SIZE+1)  local occupancy.
- o_busy  out  1  state != IDLE.
- o_drop  out  1  one-cycle pulse: zero-valued push discarded.
- o_mismatch  out  1  sticky: local count disagrees with queue flags.

Behaviour:
- Reset (i_RST high at a clock edge): state IDLE; count=0; all outputs 0. A pending response or settle is discarded.
- States:
  - IDLE: handshakes allowed.
  - ISSUE: exactly one cycle; command driven.
  - SETTLE: SETTLE_CYCLES cycles; o_pq_wrt=o_pq_read=0.
  - Then back to IDLE.
- o_push_ready = IDLE && (count<QUEUE_SIZE || (i_pop_valid && o_pop_ready)). A push into a full queue is allowed only as a replace.
- o_pop_ready = IDLE && count!=0 && !o_pop_data_valid. There is a single response slot.
- Handshakes at cycle T in IDLE register a command:
  - push only → ENQ: ISSUE at T+1 with o_pq_wrt=1, o_pq_data=key; count+1 at the end of T+1.
  - pop only → DEQ: ISSUE at T+1 with o_pq_read=1; o_pop_data <= i_pq_data at T+1; count-1.
  - both → REP: ISSUE with wrt=read=1, o_pq_data=push key; o_pop_data <= old root; count unchanged.
  - push with key==0: handshake completes; o_drop=1 at T+1; not forwarded.
    - Push only: no ISSUE, state stays IDLE.
    - With pop: degrades to DEQ.
- o_pop_data_valid rises at T+2. It holds with o_pop_data stable until i_pop_data_ready. The next pop is accepted at the earliest in the cycle after the drain.
- Latency: next handshake possible at T+2+SETTLE_CYCLES.
- o_mismatch: set in IDLE when i_pq_empty != (count==0), or when i_pq_full != (count>=QUEUE_SIZE); cleared only by reset.
- No push with count==QUEUE_SIZE && !i_pop_valid.
- No pop with count==0, even if i_pop_valid is held.
- Count arithmetic is unsigned and never wraps; the guards above make overflow and underflow unreachable.

Decomposition:
- Package pq_pkg holds:
  - state_e {IDLE, ISSUE, SETTLE}
  - cmd_e {CMD_NONE, CMD_ENQ, CMD_DEQ, CMD_REP}
  - function settle_width()
- One sub-module, pq_settle_timer: loadable down-counter. Inputs: load, value. Output: done. Instantiated once.

Test Plan:
- SETTLE_CYCLES=4, reset then push 5 at T → o_pq_wrt=1 and o_pq_data=5 at T+1 only; o_busy T+1..T+5; o_push_ready=1 again at T+6; o_count=1.
- Push 5, 9, 3 with full settling, then pop three times draining each response → o_pop_data 9, 5, 3; o_count ends 0; o_pop_ready=0 afterwards.
- Queue holding {7}, push 4 and pop in the same cycle → o_pq_wrt=o_pq_read=1 with data 4; o_pop_data=7; o_count stays 1; a following pop returns 4.
- QUEUE_SIZE=3, fill with 1, 2, 3; push 8 alone → o_push_ready=0. Push 8 with pop → replace; o_pop_data=3; count stays 3.
- Push key 0 → o_drop pulses once; o_pq_wrt never asserts; count unchanged; o_busy stays 0.
- Pop issued, hold i_pop_data_ready=0 for 10 cycles → o_pop_data_valid and o_pop_data stable and o_pop_ready=0. Assert i_RST mid-SETTLE → next cycle all outputs 0 and count 0.
